// File: rtl/lmsm_pkg.sv
// lmsm_pkg: shared FSM state type and register-file geometry for the LM/SM sequencer.
package lmsm_pkg;

    localparam int NUM_REGS  = 8;
    localparam int REG_IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/pri_enc8.sv
// pri_enc8: lowest-set-bit encoder giving index, one-hot of that bit and an any-set flag.
module pri_enc8
    import lmsm_pkg::*;
(
    input  logic [NUM_REGS-1:0]  bits,
    output logic [REG_IDX_W-1:0] idx,
    output logic [NUM_REGS-1:0]  onehot,
    output logic                 any
);

    assign onehot = bits & (~bits + NUM_REGS'(1));
    assign any    = |bits;

    // Scan high to low so the lowest set bit wins.
    always_comb begin
        idx = '0;
        for (int i = NUM_REGS - 1; i >= 0; i--)
            if (bits[i]) idx = REG_IDX_W'(i);
    end

endmodule

// File: rtl/lmsm_sequencer.sv
// lmsm_sequencer: issues one register/memory transfer per accepted cycle for LM/SM.
// Define LMSM_ADDR_ERR_EN to add the addr_err port flagging address wrap-around.
module lmsm_sequencer
    import lmsm_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int ADDR_STEP = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 is_lm,
    input  logic [NUM_REGS-1:0]  mask,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic                 ready,
    output logic                 busy,
    output logic                 stall,
    output logic                 xfer_valid,
    output logic [REG_IDX_W-1:0] rf_addr,
    output logic                 rf_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic                 mem_we,
    output logic                 done
`ifdef LMSM_ADDR_ERR_EN
    ,
    output logic                 addr_err
`endif
);

    state_t                state, state_nx;
    logic [NUM_REGS-1:0]   pending, pend_nx, low_bit;
    logic [REG_IDX_W-1:0]  idx;
    logic [ADDR_W-1:0]     cur_addr, addr_nx;
    logic                  op_lm, any, launch, take;

    pri_enc8 u_enc (
        .bits   (pending),
        .idx    (idx),
        .onehot (low_bit),
        .any    (any)
    );

    assign launch     = (state == IDLE) & start;
    assign xfer_valid = (state == XFER) & any;
    assign take       = xfer_valid & ready;
    assign pend_nx    = pending & ~low_bit;
    assign busy       = state != IDLE;
    assign stall      = busy;
    assign done       = state == DONE;
    assign rf_addr    = xfer_valid ? idx : '0;
    assign mem_addr   = xfer_valid ? cur_addr : '0;
    assign rf_we      = take & op_lm;
    assign mem_we     = take & ~op_lm;

    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nx;

    always_comb begin
        state_nx = IDLE;
        if (state == IDLE)
            state_nx = start ? ((mask != '0) ? XFER : DONE) : IDLE;
        else if (state == XFER)
            state_nx = (take && pend_nx == '0) ? DONE : XFER;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= '0;
            cur_addr <= '0;
            op_lm    <= 1'b0;
        end else if (launch) begin
            pending  <= mask;
            cur_addr <= base_addr;
            op_lm    <= is_lm;
        end else if (take) begin
            pending  <= pend_nx;
            cur_addr <= addr_nx;
        end
    end

`ifdef LMSM_ADDR_ERR_EN
    logic wrap, err_flag;

    assign {wrap, addr_nx} = {1'b0, cur_addr} + (ADDR_W + 1)'(ADDR_STEP);
    assign addr_err        = err_flag & done;

    // Sticky across the whole sequence, reported only with the done pulse.
    always_ff @(posedge clk) begin
        if (rst || launch)
            err_flag <= 1'b0;
        else if (take && wrap)
            err_flag <= 1'b1;
    end
`else
    assign addr_nx = cur_addr + ADDR_W'(ADDR_STEP);
`endif

endmodule

// File: doc/lmsm_sequencer.md
# lmsm_sequencer

Sequences the 8-entry, 16-bit register file for IITB-RISC load-multiple (LM) and store-multiple (SM) instructions. Given an 8-bit register mask and a base memory address, it issues one register/memory transfer per accepted cycle. For LM, it drives the register-file write address and write enable. For SM, it drives the register-file read address. It sits beside the decode/execute stages and stalls the pipeline front end until the sequence completes.

## Interface
Parameters:
- ADDR_W, 16, memory address width
- ADDR_STEP, 1, address increment per transferred register (word addressing)

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  launch request, sampled only in IDLE
- is_lm  in  1  1 = LM (memory→register), 0 = SM (register→memory); latched on start
- mask  in  8  bit i selects register Ri; latched on start
- base_addr  in  ADDR_W  first memory address; latched on start
- ready  in  1  downstream (memory/write-back) accepts the current transfer
- busy  out  1  sequence in progress (state ≠ IDLE)
- stall  out  1  hold fetch/decode; equals busy
- xfer_valid  out  1  rf_addr/mem_addr describe a transfer this cycle
- rf_addr  out  3  register index; LM: write address (A3), SM: read address (A2)
- rf_we  out  1  xfer_valid & is_lm & ready
- mem_addr  out  ADDR_W  memory address of current transfer
- mem_we  out  1  xfer_valid & ~is_lm & ready
- done  out  1  one-cycle completion pulse
- addr_err  out  1  present only with LMSM_ADDR_ERR_EN

## Operation
- FSM states: IDLE, XFER, DONE.
- IDLE: start=1 latches is_lm, mask→pending, base_addr→cur_addr. Transition to XFER if mask≠0. Transition to DONE if mask=0.
- XFER: xfer_valid=1, rf_addr = index of lowest set bit of pending (R0 first), mem_addr = cur_addr.
  - If ready=1: clear that bit, cur_addr += ADDR_STEP (mod 2^ADDR_W). If the updated pending = 0, go to DONE.
  - If ready=0: hold all state and outputs unchanged.
- DONE: done=1, xfer_valid=0. Go to IDLE next cycle.
- start outside IDLE is ignored; no queuing.
- The mask, is_lm and base_addr inputs are don't-care after the launch cycle.
- Reset at any time, including mid-sequence: next state IDLE, pending=0, cur_addr=0, and all outputs 0 (busy, stall, xfer_valid, rf_we, mem_we, done, addr_err, rf_addr=0, mem_addr=0). An in-flight sequence is abandoned.

## Timing
- start sampled at edge T: busy/stall high from T+1.
- First xfer_valid is in cycle T+1.
- With ready held high and N set bits, the transfers occupy cycles T+1..T+N, done is high in cycle T+N+1, and busy clears at T+N+2.
- Each ready=0 cycle in XFER adds exactly one cycle of latency.
- mask=0: done in cycle T+1, no transfers, busy high for that one cycle only.
- rf_we and mem_we are combinational in ready. All other outputs are registered or decoded from registered state.
- Back-to-back operation: a new start is accepted in the cycle after done, i.e. in IDLE.

## Configuration
- LMSM_ADDR_ERR_EN defined:
  - Port addr_err exists, with a sticky internal flag that is cleared on start.
  - The flag is set when a cur_addr increment wraps past 2^ADDR_W−1.
  - addr_err = flag & done.
  - The transfer sequence itself is unchanged.
- LMSM_ADDR_ERR_EN undefined: the addr_err port and flag are absent, and wrap-around is silent modulo arithmetic.

## Structure
- Shared package lmsm_pkg holds:
  - the FSM state typedef (IDLE/XFER/DONE)
  - NUM_REGS=8 and REG_IDX_W=3
- Sub-module pri_enc8: 8-bit lowest-set-bit encoder.
  - Outputs the 3-bit index, the one-hot of that bit (used to clear pending) and an any-set flag.
  - Purely combinational, instantiated once.

## Test plan
- LM, mask=8'b1010_0101, base=16'h0100, ready=1: rf_addr 0,2,5,7 with mem_addr 0100,0101,0102,0103 in T+1..T+4; rf_we high each; done at T+5.
- SM, mask=8'hFF, base=16'h2000, ready toggling 1,0,1,...: each rf_addr/mem_addr held across ready=0 cycles; mem_we only on ready=1; eight transfers R0..R7; done after 16 cycles.
- mask=8'h00 start: no xfer_valid, done at T+1, busy high for one cycle only; start during busy on another run has no effect.
- Reset asserted mid-XFER after 2 of 5 transfers: next cycle all outputs 0 in IDLE; a fresh start then runs from R0/base normally.
- Wrap: LM, base=16'hFFFE, mask=8'h0F: mem_addr FFFE,FFFF,0000,0001. With LMSM_ADDR_ERR_EN, addr_err=1 with done. Without it, no port and identical transfers.
